// File: rtl/mcp23s17_responder_pkg.sv
// Shared constants for the MCP23S17 responder: BANK=0 register map, IOCON bits,
// opcodes, FSM states and the register-pointer step helper.
package mcp23s17_responder_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_OPCODE, ST_ADDR, ST_DATA, ST_IGNORE} state_e;

  localparam logic [7:0] REG_ADR_IODIRA   = 8'h00;
  localparam logic [7:0] REG_ADR_IPOLA    = 8'h02;
  localparam logic [7:0] REG_ADR_GPINTENA = 8'h04;
  localparam logic [7:0] REG_ADR_IOCONA   = 8'h0A;
  localparam logic [7:0] REG_ADR_GPPUA    = 8'h0C;
  localparam logic [7:0] REG_ADR_INTCAPA  = 8'h10;
  localparam logic [7:0] REG_ADR_GPIOA    = 8'h12;
  localparam logic [7:0] REG_ADR_OLATA    = 8'h14;
  localparam logic [7:0] REG_ADR_LAST     = 8'h15;

  localparam int IOCON_MIRROR = 6;
  localparam int IOCON_SEQOP  = 5;
  localparam int IOCON_HAEN   = 3;
  localparam int IOCON_INTPOL = 1;

  localparam logic [7:0] OPC_WRITE = 8'h40;
  localparam logic [7:0] OPC_READ  = 8'h41;

  function automatic logic [7:0] ptr_step(input logic [7:0] p, input logic seqop);
    if (seqop) return p;
    return (p == REG_ADR_LAST) ? 8'h00 : p + 8'h01;
  endfunction

endpackage

// File: rtl/mcp23s17_responder_if.sv
// SPI pin bundle between an external master and the responder.
interface mcp23s17_responder_if;
  logic sck;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sck, cs_n, mosi, input miso, miso_oe);
  modport slave  (input sck, cs_n, mosi, output miso, miso_oe);
endinterface

// File: rtl/mcp23s17_responder_spi_slave_shift.sv
// Oversampled SPI mode-0 slave front end: pin synchronisers, edge detect,
// rx byte assembly and tx shifter with miso output enable.
module mcp23s17_responder_spi_slave_shift #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       rx_byte_dv,
  output logic [7:0] rx_byte,
  output logic       frame_start,
  output logic       frame_end,
  input  logic       tx_load,
  input  logic [7:0] tx_byte
);
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
  logic       sck_prev_q, cs_prev_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       armed_q, armed_d, miso_q, miso_d, oe_q, oe_d;
  logic       sck_s, cs_s, mosi_s, sck_rise, sck_fall;

  assign sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
  assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise    = sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s & sck_prev_q;
  assign frame_start = ~cs_s & cs_prev_q;
  assign frame_end   = cs_s & ~cs_prev_q;
  assign rx_byte_dv  = ~cs_s & sck_rise & (bit_cnt_q == 3'd7);
  assign rx_byte     = {rx_sh_q, mosi_s};
  assign miso        = miso_q;
  assign miso_oe     = oe_q;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_sh_d   = rx_sh_q;
    tx_sh_d   = tx_sh_q;
    armed_d   = armed_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    if (cs_s) begin
      bit_cnt_d = 3'd0;
      armed_d   = 1'b0;
      miso_d    = 1'b0;
      oe_d      = 1'b0;
    end else begin
      if (sck_rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        rx_sh_d   = {rx_sh_q[5:0], mosi_s};
      end
      // loads only happen on a rise, so they never collide with a fall shift
      if (tx_load) begin
        tx_sh_d = tx_byte;
        armed_d = 1'b1;
      end else if (sck_fall) begin
        miso_d  = tx_sh_q[7];
        tx_sh_d = {tx_sh_q[6:0], 1'b0};
        if (armed_q) oe_d = 1'b1;
      end
    end
  end

  // cs_n chain resets low: a select held at reset release never shows a fall,
  // and a deasserted select shows a rise that moves the FSM out of IGNORE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 7'd0;
      tx_sh_q     <= 8'd0;
      armed_q     <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      armed_q     <= armed_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
    end
  end
endmodule

// File: rtl/mcp23s17_responder.sv
// MCP23S17 (BANK=0) SPI responder: protocol FSM, register file, GPIO and
// interrupt-on-change logic behind the SPI shift front end.
module mcp23s17_responder
  import mcp23s17_responder_pkg::*;
#(
  parameter logic [2:0] HW_ADDR     = 3'b000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mcp23s17_responder_if.slave         spi,
  input  logic [7:0]                  gpio_a_in,
  input  logic [7:0]                  gpio_b_in,
  output logic [7:0]                  gpio_a_out,
  output logic [7:0]                  gpio_b_out,
  output logic [7:0]                  gpio_a_oe,
  output logic [7:0]                  gpio_b_oe,
  output logic                        inta,
  output logic                        intb
);
  state_e          state_q, state_d;
  logic [7:0]      ptr_q, ptr_d, ld_addr, tx_byte, rx_byte, iocon_q, iocon_d, gpio_rd;
  logic            rd_q, rd_d, wr_en, tx_load, rx_byte_dv, frame_start, frame_end, lp;
  logic [1:0][7:0] iodir_q, iodir_d, ipol_q, ipol_d, gpinten_q, gpinten_d, gppu_q, gppu_d;
  logic [1:0][7:0] olat_q, olat_d, intcap_q, intcap_d, pin_q, pin_prev_q;
  logic [1:0]      flag_q, flag_d, chg, clr, set;

  mcp23s17_responder_spi_slave_shift #(.SYNC_STAGES(SYNC_STAGES)) u_spi_slave_shift (
    .clk(clk), .rst_n(rst_n), .sck(spi.sck), .cs_n(spi.cs_n), .mosi(spi.mosi),
    .miso(spi.miso), .miso_oe(spi.miso_oe), .rx_byte_dv(rx_byte_dv), .rx_byte(rx_byte),
    .frame_start(frame_start), .frame_end(frame_end), .tx_load(tx_load), .tx_byte(tx_byte)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rd_d    = rd_q;
    wr_en   = 1'b0;
    tx_load = 1'b0;
    ld_addr = ptr_q;
    if (frame_end) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE:   if (frame_start) state_d = ST_OPCODE;
        ST_OPCODE: if (rx_byte_dv) begin
          if (rx_byte[7:4] == OPC_WRITE[7:4] &&
              (!iocon_q[IOCON_HAEN] || rx_byte[3:1] == HW_ADDR)) begin
            state_d = ST_ADDR;
            rd_d    = rx_byte[0];
          end else state_d = ST_IGNORE;
        end
        ST_ADDR: if (rx_byte_dv) begin
          ptr_d   = rx_byte;
          ld_addr = rx_byte;
          tx_load = rd_q;
          state_d = ST_DATA;
        end
        ST_DATA: if (rx_byte_dv) begin
          wr_en   = ~rd_q;
          ptr_d   = ptr_step(ptr_q, iocon_q[IOCON_SEQOP]);
          ld_addr = ptr_d;
          tx_load = rd_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    iodir_d   = iodir_q;
    ipol_d    = ipol_q;
    gpinten_d = gpinten_q;
    gppu_d    = gppu_q;
    olat_d    = olat_q;
    iocon_d   = iocon_q;
    if (wr_en) begin
      case ({ptr_q[7:1], 1'b0})
        REG_ADR_IODIRA:               iodir_d[ptr_q[0]]   = rx_byte;
        REG_ADR_IPOLA:                ipol_d[ptr_q[0]]    = rx_byte;
        REG_ADR_GPINTENA:             gpinten_d[ptr_q[0]] = rx_byte;
        REG_ADR_GPPUA:                gppu_d[ptr_q[0]]    = rx_byte;
        REG_ADR_IOCONA:               iocon_d             = rx_byte;
        REG_ADR_GPIOA, REG_ADR_OLATA: olat_d[ptr_q[0]]    = rx_byte;
        default: ;
      endcase
    end
  end

  always_comb begin
    lp      = ld_addr[0];
    gpio_rd = (iodir_q[lp] & (pin_q[lp] ^ ipol_q[lp])) | (~iodir_q[lp] & olat_q[lp]);
    tx_byte = 8'h00;
    case ({ld_addr[7:1], 1'b0})
      REG_ADR_IODIRA:   tx_byte = iodir_q[lp];
      REG_ADR_IPOLA:    tx_byte = ipol_q[lp];
      REG_ADR_GPINTENA: tx_byte = gpinten_q[lp];
      REG_ADR_IOCONA:   tx_byte = iocon_q;
      REG_ADR_GPPUA:    tx_byte = gppu_q[lp];
      REG_ADR_INTCAPA:  tx_byte = intcap_q[lp];
      REG_ADR_GPIOA:    tx_byte = gpio_rd;
      REG_ADR_OLATA:    tx_byte = olat_q[lp];
      default: ;
    endcase
  end

  // a change coinciding with the clearing read wins, so no edge is lost
  always_comb begin
    flag_d   = flag_q;
    intcap_d = intcap_q;
    for (int p = 0; p < 2; p++) begin
      chg[p] = |((pin_q[p] ^ pin_prev_q[p]) & gpinten_q[p] & iodir_q[p]);
      clr[p] = tx_load && (ld_addr[0] == p[0]) &&
               ({ld_addr[7:1], 1'b0} == REG_ADR_GPIOA || {ld_addr[7:1], 1'b0} == REG_ADR_INTCAPA);
      set[p] = chg[p] & (~flag_q[p] | clr[p]);
      if (set[p]) begin
        flag_d[p]   = 1'b1;
        intcap_d[p] = pin_q[p];
      end else if (clr[p]) flag_d[p] = 1'b0;
    end
  end

  // INTPOL=0 is active-low, so the idle level out of reset is 1
  assign inta = (iocon_q[IOCON_MIRROR] ? |flag_q : flag_q[0]) ^ ~iocon_q[IOCON_INTPOL];
  assign intb = (iocon_q[IOCON_MIRROR] ? |flag_q : flag_q[1]) ^ ~iocon_q[IOCON_INTPOL];
  assign gpio_a_out = olat_q[0];
  assign gpio_b_out = olat_q[1];
  assign gpio_a_oe  = ~iodir_q[0];
  assign gpio_b_oe  = ~iodir_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IGNORE;
      ptr_q      <= 8'h00;
      rd_q       <= 1'b0;
      iodir_q    <= {2{8'hFF}};
      ipol_q     <= '0;
      gpinten_q  <= '0;
      gppu_q     <= '0;
      olat_q     <= '0;
      intcap_q   <= '0;
      iocon_q    <= 8'h00;
      flag_q     <= 2'b00;
      pin_q      <= '0;
      pin_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_q       <= rd_d;
      iodir_q    <= iodir_d;
      ipol_q     <= ipol_d;
      gpinten_q  <= gpinten_d;
      gppu_q     <= gppu_d;
      olat_q     <= olat_d;
      intcap_q   <= intcap_d;
      iocon_q    <= iocon_d;
      flag_q     <= flag_d;
      pin_q      <= {gpio_b_in, gpio_a_in};
      pin_prev_q <= pin_q;
    end
  end
endmodule

// File: tb/tb_mcp23s17_responder.sv
// Directed bench for the MCP23S17 responder: a mode-0 SPI master task drives
// frames, expected read bytes go through a scoreboard queue.
module tb_mcp23s17_responder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] gpio_a_in, gpio_b_in, gpio_a_out, gpio_b_out, gpio_a_oe, gpio_b_oe;
  logic       inta, intb;
  logic       oe_seen, oe_hdr, int_adr;
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  mcp23s17_responder_if s();

  mcp23s17_responder #(.HW_ADDR(3'b000), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi(s),
    .gpio_a_in(gpio_a_in), .gpio_b_in(gpio_b_in),
    .gpio_a_out(gpio_a_out), .gpio_b_out(gpio_b_out),
    .gpio_a_oe(gpio_a_oe), .gpio_b_oe(gpio_b_oe),
    .inta(inta), .intb(intb)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One byte, MSB first; miso sampled at each rise. flip toggles gpio_a_in[0]
  // one clk after the last rise so it lands in the same clk as the tx load.
  task automatic spi_byte(input logic [7:0] b, input int nbits, input bit flip, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      s.mosi = b[i];
      repeat (4) @(negedge clk);
      s.sck = 1'b1;
      r[i] = s.miso;
      oe_seen = oe_seen | s.miso_oe;
      if (flip && i == 0) begin
        @(negedge clk);
        gpio_a_in[0] = ~gpio_a_in[0];
        repeat (3) @(negedge clk);
      end else repeat (4) @(negedge clk);
      s.sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] op, input logic [7:0] adr, input int ndata,
                       input logic [7:0] d0 = 8'h00, input int dbits = 8, input bit flip_adr = 1'b0);
    logic [7:0] r;
    oe_seen = 1'b0;
    s.cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(op, 8, 1'b0, r);
    spi_byte(adr, 8, flip_adr, r);
    oe_hdr  = oe_seen;
    int_adr = inta;
    for (int i = 0; i < ndata; i++) begin
      spi_byte(d0, dbits, 1'b0, r);
      if (op[0]) chk("miso_byte", r, (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx);
    end
    repeat (4) @(negedge clk);
    s.cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [7:0] r;
    rst_n = 1'b0; s.cs_n = 1'b1; s.sck = 1'b0; s.mosi = 1'b0;
    gpio_a_in = 8'h00; gpio_b_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_a_oe", gpio_a_oe, 8'h00);
    chk("rst_b_oe", gpio_b_oe, 8'h00);
    chk("rst_a_out", gpio_a_out, 8'h00);
    chk("rst_miso", {s.miso_oe, s.miso}, 8'h00);
    chk("rst_int", {inta, intb}, 8'h03);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // direction write, readback
    frame(8'h40, 8'h00, 1, 8'h00);
    chk("iodira_oe", gpio_a_oe, 8'hFF);
    exp_q.push_back(8'h00);
    frame(8'h41, 8'h00, 1);

    // GPIO read with input polarity
    frame(8'h40, 8'h00, 1, 8'hFF);
    frame(8'h40, 8'h02, 1, 8'h0F);
    gpio_a_in = 8'hA5;
    exp_q.push_back(8'hAA);
    frame(8'h41, 8'h12, 1);
    chk("oe_hdr", oe_hdr, 8'h00);
    chk("oe_data", oe_seen, 8'h01);

    // sequential read with wrap, then SEQOP hold
    frame(8'h40, 8'h14, 1, 8'h11);
    frame(8'h40, 8'h15, 1, 8'h22);
    chk("olata", gpio_a_out, 8'h11);
    chk("olatb", gpio_b_out, 8'h22);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'hFF);
    frame(8'h41, 8'h14, 3);
    frame(8'h40, 8'h0A, 1, 8'h20);
    repeat (3) exp_q.push_back(8'h11);
    frame(8'h41, 8'h14, 3);
    frame(8'h40, 8'h0A, 1, 8'h00);

    // hardware address match
    frame(8'h40, 8'h0A, 1, 8'h08);
    frame(8'h42, 8'h14, 1, 8'h55);
    chk("haen_nowrite", gpio_a_out, 8'h11);
    chk("haen_oe", oe_seen, 8'h00);
    frame(8'h40, 8'h0A, 1, 8'h00);
    frame(8'h42, 8'h14, 1, 8'h55);
    chk("nohaen_write", gpio_a_out, 8'h55);

    // interrupt on change, mirrored, active high
    frame(8'h40, 8'h0A, 1, 8'h52);
    frame(8'h40, 8'h04, 1, 8'h01);
    gpio_a_in[0] = 1'b0;
    @(negedge clk);
    chk("int_1clk", inta, 8'h00);
    @(negedge clk);
    chk("int_2clk", {inta, intb}, 8'h03);
    exp_q.push_back(8'hAB);
    frame(8'h41, 8'h12, 1);
    chk("int_clr_load", int_adr, 8'h00);
    gpio_a_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("int_refire", inta, 8'h01);
    exp_q.push_back(8'hA5);
    frame(8'h41, 8'h10, 1);
    chk("intcap_clr", inta, 8'h00);
    gpio_a_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    frame(8'h41, 8'h12, 0, 8'h00, 8, 1'b1);
    chk("chg_wins", {inta, intb}, 8'h03);
    exp_q.push_back(8'hA5);
    frame(8'h41, 8'h10, 1);
    chk("intcap_new", inta, 8'h00);

    // aborted data byte
    frame(8'h40, 8'h14, 1, 8'hFF, 5);
    chk("partial", gpio_a_out, 8'h55);

    // reset mid-frame with cs_n held low
    s.cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h40, 8, 1'b0, r);
    spi_byte(8'h14, 8, 1'b0, r);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_out", gpio_a_out, 8'h00);
    chk("mid_rst_int", {inta, intb}, 8'h03);
    rst_n = 1'b1;
    spi_byte(8'h77, 8, 1'b0, r);
    spi_byte(8'h40, 8, 1'b0, r);
    spi_byte(8'h14, 8, 1'b0, r);
    spi_byte(8'h77, 8, 1'b0, r);
    chk("ignore_after_rst", gpio_a_out, 8'h00);
    chk("ignore_oe", s.miso_oe, 8'h00);
    repeat (4) @(negedge clk);
    s.cs_n = 1'b1;
    repeat (8) @(negedge clk);
    frame(8'h40, 8'h14, 1, 8'h77);
    chk("write_after_rst", gpio_a_out, 8'h77);
    chk("sb_empty", exp_q.size(), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
